mem_access_stage: RTL

Memory-access/writeback stage that sits directly after the execute stage and consumes its registered outputs: ALU result, register-write request, destination register and halt. It turns store/load requests into a req/ack transaction on the data-memory port, stalling upstream while the transaction is open. It drives the register-file write port and returns `mem_value` to execute for operand forwarding. A watchdog counter aborts memory transactions that are never acknowledged.

---
 rtl/mem_access_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory-access/writeback stage: turns loads/stores into a req/ack data-memory
// transaction, drives the register-file write port and a forwarding value.
module mem_access_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic              in_is_mem_write,
  input  logic              in_is_mem_read,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] in_reg_addr,
  input  logic              in_halt,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] mem_value,
  output logic              halted,
  output logic              err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  logic [1:0]        state;
  logic [15:0]       cnt;
  logic              pend_rw;
  logic [REG_AW-1:0] pend_addr;
  logic [15:0]       cnt_inc;

  assign stall   = (state != S_IDLE);
  assign cnt_inc = cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      pend_rw    <= 1'b0;
      pend_addr  <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_we      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      mem_value  <= '0;
      halted     <= 1'b0;
      err        <= 1'b0;
    end else begin
      wb_we <= 1'b0;
      if (wb_we) mem_value <= wb_data;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            // Halt wins over a memory request; its register write still lands.
            if (in_halt) begin
              state   <= S_HALT;
              halted  <= 1'b1;
              wb_we   <= in_reg_write;
              wb_addr <= in_reg_addr;
              wb_data <= in_result;
            end else if (in_is_mem_write || in_is_mem_read) begin
              state      <= S_BUSY;
              cnt        <= '0;
              dmem_req   <= 1'b1;
              dmem_we    <= in_is_mem_write;
              dmem_addr  <= in_result;
              dmem_wdata <= in_store_data;
              pend_rw    <= in_reg_write;
              pend_addr  <= in_reg_addr;
            end else begin
              wb_we   <= in_reg_write;
              wb_addr <= in_reg_addr;
              wb_data <= in_result;
            end
          end
        end
        S_BUSY: begin
          // An ack on the timeout edge completes normally.
          if (dmem_ack) begin
            state    <= S_IDLE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            wb_we    <= pend_rw;
            wb_addr  <= pend_addr;
            wb_data  <= dmem_we ? dmem_addr : dmem_rdata;
          end else if (cnt_inc == TO_CNT) begin
            state    <= S_HALT;
            cnt      <= cnt_inc;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            err      <= 1'b1;
            halted   <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
